// File: rtl/rr_trace_buf_sched_pkg.sv
// Shared types for the trace host-buffer scheduler: descriptor layout,
// scheduler state encoding and error-cause codes.
package rr_trace_buf_pkg;

    localparam int RR_ADDR_W_MAX = 64;
    localparam int RR_SIZE_W_MAX = 32;

    typedef struct packed {
        logic [RR_ADDR_W_MAX-1:0] addr;
        logic [RR_SIZE_W_MAX-1:0] size;
    } rr_buf_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACTIVE,
        ST_WAIT_CREDIT,
        ST_FLUSH
    } rr_sched_state_e;

    // Error causes, kept for a future CSR readback of the sticky err flag
    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_BAD_CFG,
        ERR_CREDIT_OVF,
        ERR_IDLE_RELEASE,
        ERR_STRAY_DONE,
        ERR_DESC_BUSY
    } rr_err_cause_e;

endpackage

// File: rtl/rr_trace_buf_sched_if.sv
// Scheduler <-> trace engine link: armed buffer, load/flush pulses and the
// engine's buffer-done interrupt.
interface rr_trace_buf_sched_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [SIZE_WIDTH-1:0] buf_size;
    logic                  write_buf_update;
    logic                  read_buf_update;
    logic                  record_force_finish;
    logic                  buf_done;

    modport master (
        output buf_addr, buf_size, write_buf_update, read_buf_update, record_force_finish,
        input  buf_done
    );

    modport slave (
        input  buf_addr, buf_size, write_buf_update, read_buf_update, record_force_finish,
        output buf_done
    );
endinterface

// File: rtl/rr_trace_buf_sched_credit.sv
// Saturating up/down credit counter; ovf flags an increment dropped at max.
module rr_credit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         ovf
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            if (count != max_val) count <= count + W'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - W'(1);
        end
    end

    assign ovf = inc && !dec && !load && (count == max_val);

endmodule

// File: rtl/rr_trace_buf_sched.sv
// Host-buffer ring scheduler: arms descriptors to the trace engine one at a
// time, advances on buffer-done, stalls on missing credits, sequences flush.
module rr_trace_buf_sched
    import rr_trace_buf_pkg::*;
#(
    parameter int NUM_BUFS   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 32,
    localparam int IDX_W     = $clog2(NUM_BUFS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  desc_wr_valid,
    input  logic [IDX_W-1:0]      desc_wr_idx,
    input  logic [ADDR_WIDTH-1:0] desc_wr_addr,
    input  logic [SIZE_WIDTH-1:0] desc_wr_size,
    input  logic [IDX_W:0]        num_bufs_cfg,
    input  logic                  start_record,
    input  logic                  start_replay,
    input  logic                  stop,
    input  logic                  buf_release,
    rr_trace_buf_sched_if.master  eng,
    output logic                  busy,
    output logic                  mode,
    output logic [IDX_W-1:0]      cur_idx,
    output logic [IDX_W:0]        credits,
    output logic                  err
);

    localparam logic [IDX_W:0] NUM_BUFS_C = (IDX_W+1)'(NUM_BUFS);

    rr_sched_state_e       state_q, state_d;
    rr_buf_desc_t          desc_q [NUM_BUFS];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W:0]        cfg_q, cfg_d;
    logic                  mode_q, mode_d;
    logic                  err_q, err_d;
    logic                  flush_q, flush_d;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic                  wr_upd_q, wr_upd_d;
    logic                  rd_upd_q, rd_upd_d;
    logic                  ff_q, ff_d;
    logic                  load_desc, desc_we;
    logic                  cnt_load, cnt_inc, cnt_dec, cnt_ovf;
    logic                  err_set, err_clr;
    logic                  start_any, cfg_ok, credit_avail;
    logic [IDX_W:0]        idx_inc;
    logic [IDX_W-1:0]      idx_adv;

    assign start_any    = start_record || start_replay;
    assign cfg_ok       = (num_bufs_cfg != '0) && (num_bufs_cfg <= NUM_BUFS_C);
    assign credit_avail = (credits != '0);
    assign idx_inc      = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign idx_adv      = (idx_inc == cfg_q) ? '0 : idx_inc[IDX_W-1:0];

    rr_credit_counter #(.W(IDX_W+1)) u_credits (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (num_bufs_cfg),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .max_val  (cfg_q),
        .count    (credits),
        .ovf      (cnt_ovf)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cfg_d     = cfg_q;
        mode_d    = mode_q;
        flush_d   = flush_q;
        wr_upd_d  = 1'b0;
        rd_upd_d  = 1'b0;
        ff_d      = 1'b0;
        load_desc = 1'b0;
        desc_we   = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = buf_release && (state_q != ST_IDLE);
        cnt_dec   = (state_q == ST_ARM);
        err_set   = 1'b0;
        err_clr   = 1'b0;

        if (buf_release && state_q == ST_IDLE) err_set = 1'b1;
        if (cnt_ovf) err_set = 1'b1;
        if (desc_wr_valid) begin
            if (state_q == ST_IDLE) desc_we = 1'b1;
            else                    err_set = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (eng.buf_done) err_set = 1'b1;
                if (start_any) begin
                    if (cfg_ok) begin
                        mode_d   = !start_record;
                        cfg_d    = num_bufs_cfg;
                        idx_d    = '0;
                        flush_d  = 1'b0;
                        cnt_load = 1'b1;
                        err_clr  = 1'b1;
                        state_d  = ST_ARM;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (eng.buf_done) err_set = 1'b1;
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = ST_FLUSH;
                end else if (stop) begin
                    ff_d    = !mode_q;
                    state_d = mode_q ? ST_IDLE : ST_FLUSH;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (eng.buf_done) begin
                    idx_d = idx_adv;
                    // done+stop in record: re-arm once carrying the flush, then FLUSH
                    if (stop && !mode_q) begin
                        if (credit_avail) begin
                            ff_d    = 1'b1;
                            flush_d = 1'b1;
                            state_d = ST_ARM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = credit_avail ? ST_ARM : ST_WAIT_CREDIT;
                    end
                end else if (stop) begin
                    ff_d    = !mode_q;
                    state_d = mode_q ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_WAIT_CREDIT: begin
                if (eng.buf_done) err_set = 1'b1;
                if (stop)              state_d = ST_IDLE;
                else if (credit_avail) state_d = ST_ARM;
            end
            ST_FLUSH: begin
                if (eng.buf_done) begin
                    idx_d   = idx_adv;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ARM) begin
            load_desc = 1'b1;
            wr_upd_d  = !mode_d;
            rd_upd_d  = mode_d;
        end

        err_d = (err_clr ? 1'b0 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cfg_q    <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            wr_upd_q <= 1'b0;
            rd_upd_q <= 1'b0;
            ff_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cfg_q    <= cfg_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            flush_q  <= flush_d;
            busy_q   <= (state_d != ST_IDLE);
            wr_upd_q <= wr_upd_d;
            rd_upd_q <= rd_upd_d;
            ff_q     <= ff_d;
            if (load_desc) begin
                addr_q <= desc_q[idx_d].addr[ADDR_WIDTH-1:0];
                size_q <= desc_q[idx_d].size[SIZE_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_BUFS; i++) desc_q[i] <= '0;
        end else if (desc_we && ({1'b0, desc_wr_idx} < NUM_BUFS_C)) begin
            desc_q[desc_wr_idx].addr <= RR_ADDR_W_MAX'(desc_wr_addr);
            desc_q[desc_wr_idx].size <= RR_SIZE_W_MAX'(desc_wr_size);
        end
    end

    assign eng.buf_addr            = addr_q;
    assign eng.buf_size            = size_q;
    assign eng.write_buf_update    = wr_upd_q;
    assign eng.read_buf_update     = rd_upd_q;
    assign eng.record_force_finish = ff_q;
    assign busy                    = busy_q;
    assign mode                    = mode_q;
    assign cur_idx                 = idx_q;
    assign err                     = err_q;

endmodule

// File: doc/rr_trace_buf_sched.md
# rr_trace_buf_sched

Host-buffer scheduler for the trace read/write engine behind the AXI storage backend. Holds a small ring of host buffer descriptors programmed over CSR and hands them to the engine one at a time via `buf_addr`/`buf_size` plus a `write_buf_update` (record) or `read_buf_update` (replay) pulse. Advances on each buffer-done event and stalls when the host has not returned buffers. In record mode, sequences the final flush through `record_force_finish`.

## Interface
- `NUM_BUFS`, 4: descriptor ring depth (2..16).
- `ADDR_WIDTH`, 64: host address width.
- `SIZE_WIDTH`, 32: buffer size width (bytes).
- `IDX_W`, `$clog2(NUM_BUFS)`: derived localparam, not overridable.
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `desc_wr_valid`  in  1  descriptor write strobe.
- `desc_wr_idx`  in  IDX_W  descriptor slot.
- `desc_wr_addr`  in  ADDR_WIDTH  buffer base.
- `desc_wr_size`  in  SIZE_WIDTH  buffer size.
- `num_bufs_cfg`  in  IDX_W+1  active ring length.
- `start_record` / `start_replay`  in  1  single-cycle start pulses.
- `stop`  in  1  single-cycle stop pulse.
- `buf_done`  in  1  engine finished the current buffer (write/read interrupt).
- `buf_release`  in  1  host returns one buffer.
- `buf_addr`  out  ADDR_WIDTH  current descriptor base.
- `buf_size`  out  SIZE_WIDTH  current descriptor size.
- `write_buf_update` / `read_buf_update`  out  1  one-cycle load pulses.
- `record_force_finish`  out  1  one-cycle flush pulse.
- `busy`  out  1  state != IDLE.
- `mode`  out  1  0 = record, 1 = replay.
- `cur_idx`  out  IDX_W  ring index currently armed.
- `credits`  out  IDX_W+1  buffers owned by the FPGA.
- `err`  out  1  sticky protocol-error flag; cleared only by reset or an accepted start.

## Operation
- States: IDLE, ARM, ACTIVE, WAIT_CREDIT, FLUSH.
- IDLE: descriptor writes are accepted. A start is accepted only if `1 <= num_bufs_cfg <= NUM_BUFS`; otherwise it is ignored and `err` is set. An accepted start latches `mode` and `num_bufs_cfg`, sets `cur_idx`=0 and `credits`=`num_bufs_cfg`, clears `err`, and moves to ARM.
- If `start_record` and `start_replay` arrive together: record wins.
- ARM (one cycle): pulse the update line selected by `mode`, decrement `credits`, then go to ACTIVE.
- ACTIVE, `buf_done`: `cur_idx` <- (`cur_idx`+1) mod latched cfg. If `credits`>0, go to ARM; else go to WAIT_CREDIT.
- WAIT_CREDIT: go to ARM on the first cycle `credits`>0.
- `stop` in record mode (ARM/ACTIVE/WAIT_CREDIT):
  - from ACTIVE or ARM, pulse `record_force_finish` and go to FLUSH;
  - from WAIT_CREDIT, go straight to IDLE with no flush, since no buffer is armed.
- FLUSH: on `buf_done`, advance `cur_idx` and go to IDLE.
- `stop` in replay mode: go to IDLE immediately, no pulses.
- `buf_release`: `credits`+1, saturating at the latched cfg. A release at saturation, or while in IDLE, is dropped and sets `err`.
- Simultaneous ARM decrement and release: net unchanged.
- `buf_done` outside ACTIVE/FLUSH is ignored and sets `err`.
- `desc_wr_valid` while `busy` is ignored and sets `err`.
- `stop` in IDLE is ignored.
- Simultaneous `buf_done` and `stop` in ACTIVE (record): `buf_done` is processed first (index advances), then the flush is issued from the next ARM-equivalent decision. Implement as: go to FLUSH with `cur_idx` advanced. If `credits`>0, pulse `record_force_finish` in the same cycle as re-arming, i.e. pass through ARM for one cycle, then FLUSH. If `credits`=0, go to IDLE.

## Timing
- All outputs are registered.
- Reset values: `buf_addr`/`buf_size`/`cur_idx`/`credits`/`mode`/`err`/`busy` = 0; all pulses = 0; state IDLE; descriptor RAM = 0.
- Start sampled at cycle N: update pulse and valid `buf_addr`/`buf_size` at N+1.
- `buf_done` at N with credit available: next update pulse at N+1, new address at N+1.
- Release at N while in WAIT_CREDIT: `credits` updates at N+1, update pulse at N+2.
- `buf_addr`/`buf_size` change only in the cycle an update pulse asserts, and hold until the next one.
- Reset asserted mid-operation: all state clears asynchronously; the engine must be reset by the same `rstn`.

## Structure
- Shared package `rr_trace_buf_pkg` holds:
  - `rr_buf_desc_t` (addr, size);
  - the state enum;
  - the `err` cause encoding, reserved for later CSR readback.
- Descriptor storage is a flop array `rr_buf_desc_t [NUM_BUFS]`, read combinationally by `cur_idx` into the output registers.
- Optional sub-module `rr_credit_counter`: saturating up/down counter with overflow flag.

## Test plan
- Ring of 4 descriptors (0x1000, 0x2000, 0x3000, 0x4000, size 0x100), `start_record`, four `buf_done` with a release after each → update pulses carry addresses 1000, 2000, 3000, 4000, 1000 in order, `credits` stays ≥1, `err`=0.
- `num_bufs_cfg`=2, no releases, two `buf_done` → state WAIT_CREDIT, `credits`=0, no third pulse. One `buf_release` → update at +2 cycles with addr of slot 0.
- Record, `stop` in ACTIVE → `record_force_finish` pulse 1 cycle later, FLUSH. `buf_done` → IDLE, `busy`=0, `cur_idx` advanced by 1.
- Replay start → only `read_buf_update` pulses; `stop` → IDLE next cycle, `record_force_finish` never asserts.
- Errors:
  - `num_bufs_cfg`=0 start → ignored, `err`=1;
  - release at full credits → `err`=1, `credits` unchanged;
  - descriptor write while busy → RAM unchanged.
- Async reset asserted in ACTIVE between clock edges → all outputs 0 immediately; a subsequent start re-arms slot 0.
